time_chain_ctrl: RTL and testbench
==================================

# time_chain_ctrl

Parametrised time-of-day counter chain with run/set/hold control, successor to the fixed hour/minute/second clock-enable steering block. Holds the seconds, minutes and hours counters internally with configurable moduli and an integrated tick prescaler. In SET mode an edge-detected field selector and increment input adjust any one of the three fields. Sits between the debounced front-panel inputs and the display encoder.

## Interface
- TICK_DIV, 50000000: clk cycles per seconds tick; must be ≥ 2.
- SEC_MOD, 60: seconds modulus; must be ≥ 2.
- MIN_MOD, 60: minutes modulus; must be ≥ 2.
- HOUR_MOD, 24: hours modulus; must be ≥ 2.
- REPEAT_DLY, 16: change-held cycles before auto-repeat starts; used only with AUTO_REPEAT_EN.
- REPEAT_PER, 4: cycles between auto-repeat increments; used only with AUTO_REPEAT_EN.
- clk  in  1  single system clock; all state updates on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- mode  in  2  00 RUN, 01 SET, 10 HOLD, 11 treated as HOLD.
- turn  in  1  debounced level; a rising edge advances the SET field selector.
- change  in  1  debounced level; a rising edge increments the selected field in SET.
- sec  out  clog2(SEC_MOD)  seconds value, 0..SEC_MOD-1.
- min  out  clog2(MIN_MOD)  minutes value.
- hour  out  clog2(HOUR_MOD)  hours value.
- sel  out  2  selected field: 00 SEC, 01 MIN, 10 HOUR.
- tick_m  out  1  one-cycle pulse when seconds wrap in RUN.
- tick_h  out  1  one-cycle pulse when minutes wrap in RUN.
- tick_d  out  1  one-cycle pulse when hours wrap in RUN (day rollover).

## Operation
- Reset: sec = min = hour = 0, sel = 10 (HOUR), tick_* = 0, prescaler = 0, edge registers = 0.
- RUN:
  - Prescaler counts 0..TICK_DIV-1 and wraps.
  - Its terminal count increments sec. When sec = SEC_MOD-1, sec goes to 0, min increments and tick_m fires.
  - Min and hour cascade the same way, raising tick_h and tick_d.
  - All cascaded fields update on the same edge.
  - turn and change are ignored.
- SET:
  - Prescaler is held at 0 and no field counts on its own.
  - A turn rising edge steps sel HOUR→MIN→SEC→HOUR.
  - A change rising edge increments the field named by sel, modulo its modulus, with no carry into other fields. tick_* stay 0.
- HOLD: all counters and the prescaler freeze, inputs are ignored, and tick_* stay 0.
- Edge detection: turn and change are each registered. An edge is current input = 1 with the registered copy = 0. The registers update in every mode, so a level already high on entry to SET is not an edge.
- Simultaneous turn and change edges: the increment applies to the old sel, and sel advances on the same edge.
- Mode transitions:
  - Any transition clears the prescaler to 0.
  - Leaving SET for RUN: the first seconds tick occurs TICK_DIV cycles later.
  - sel is retained across modes.
- Field values are always within modulus. There are no illegal states. sel = 11 is unreachable and, if it occurs, decodes as HOUR.

## Timing
- Fields, sel and tick_* are registered outputs.
- change or turn edge sampled at edge n: the field or sel update is visible after edge n, so latency is one cycle from the first high sample.
- tick_m, tick_h and tick_d are high for exactly the cycle following the wrap edge, coincident with the new field values.
- RUN tick spacing is exactly TICK_DIV cycles.
- rst asserted mid-operation forces the reset values immediately, without waiting for a clock edge. Release is synchronous to the next clk edge.

## Configuration
- AUTO_REPEAT_EN defined:
  - In SET, change held high for REPEAT_DLY consecutive cycles after its edge generates an increment.
  - It then generates a further increment every REPEAT_PER cycles while change stays high.
  - change low, a mode change, or a turn edge resets the repeat counter.
- AUTO_REPEAT_EN undefined: only rising edges increment, the repeat logic is absent, and REPEAT_DLY and REPEAT_PER have no effect.

## Test plan
- Reset release, TICK_DIV=4, RUN for 4 cycles → sec=1 on edge 4; nothing else changes; all tick_* = 0.
- Preload 23:59:59 via SET, RUN with TICK_DIV=4 → after 4 cycles 00:00:00, with tick_m, tick_h and tick_d high together for one cycle.
- SET, sel=HOUR, 25 change pulses with HOUR_MOD=24 → hour=1; min and sec unchanged.
- SET, turn and change rise on the same cycle with sel=HOUR → hour+1 and sel=MIN; min unchanged.
- RUN at prescaler=2, switch to HOLD for 10 cycles, then back to RUN → next tick 4 cycles after re-entry; counts frozen during HOLD.
- With AUTO_REPEAT_EN, REPEAT_DLY=16, REPEAT_PER=4: change held 28 cycles in SET on SEC from 0 → sec=5 (1 edge + 4 repeats); without the macro → sec=1.

Source files
------------

// File: rtl/time_chain_ctrl.sv
// Seconds/minutes/hours counter chain with tick prescaler and RUN/SET/HOLD control.
// Optional feature macro: AUTO_REPEAT_EN (held change auto-repeats in SET mode).
module time_chain_ctrl #(
    parameter int TICK_DIV   = 50000000,
    parameter int SEC_MOD    = 60,
    parameter int MIN_MOD    = 60,
    parameter int HOUR_MOD   = 24,
    parameter int REPEAT_DLY = 16,
    parameter int REPEAT_PER = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [1:0]                  mode,
    input  logic                        turn,
    input  logic                        change,
    output logic [$clog2(SEC_MOD)-1:0]  sec,
    output logic [$clog2(MIN_MOD)-1:0]  min,
    output logic [$clog2(HOUR_MOD)-1:0] hour,
    output logic [1:0]                  sel,
    output logic                        tick_m,
    output logic                        tick_h,
    output logic                        tick_d
);

    localparam int SW = $clog2(SEC_MOD);
    localparam int MW = $clog2(MIN_MOD);
    localparam int HW = $clog2(HOUR_MOD);
    localparam int PW = $clog2(TICK_DIV);

    localparam logic [SW-1:0] SEC_MAX  = SW'(SEC_MOD - 1);
    localparam logic [MW-1:0] MIN_MAX  = MW'(MIN_MOD - 1);
    localparam logic [HW-1:0] HOUR_MAX = HW'(HOUR_MOD - 1);
    localparam logic [PW-1:0] PRE_MAX  = PW'(TICK_DIV - 1);

    if (TICK_DIV < 2 || SEC_MOD < 2 || MIN_MOD < 2 || HOUR_MOD < 2 ||
        REPEAT_PER < 1 || REPEAT_DLY <= REPEAT_PER) begin : g_bad_params
        $error("time_chain_ctrl: illegal parameter combination");
    end

    typedef enum logic [1:0] {
        MODE_RUN  = 2'b00,
        MODE_SET  = 2'b01,
        MODE_HOLD = 2'b10
    } mode_e;

    typedef enum logic [1:0] {
        SEL_SEC  = 2'b00,
        SEL_MIN  = 2'b01,
        SEL_HOUR = 2'b10
    } sel_e;

    mode_e         cur_mode;
    sel_e          sel_dec;
    logic [PW-1:0] prescale;
    logic          turn_q;
    logic          change_q;
    logic          turn_rise;
    logic          change_rise;
    logic          inc;

    // NOTE: every combinational output gets a value on every path, so no latch is inferred.
    always_comb begin
        cur_mode = MODE_HOLD;
        case (mode)
            2'b00:   cur_mode = MODE_RUN;
            2'b01:   cur_mode = MODE_SET;
            default: cur_mode = MODE_HOLD;
        endcase
    end

    always_comb begin
        sel_dec = SEL_HOUR;
        case (sel)
            2'b00:   sel_dec = SEL_SEC;
            2'b01:   sel_dec = SEL_MIN;
            default: sel_dec = SEL_HOUR;
        endcase
    end

    assign turn_rise   = turn & ~turn_q;
    assign change_rise = change & ~change_q;

`ifdef AUTO_REPEAT_EN
    localparam int RW = $clog2(REPEAT_DLY + 1);
    localparam logic [RW-1:0] RPT_LAST   = RW'(REPEAT_DLY - 1);
    localparam logic [RW-1:0] RPT_RELOAD = RW'(REPEAT_DLY - REPEAT_PER);

    // rpt_cnt = 0 means disarmed; only a real change edge arms it.
    logic [RW-1:0] rpt_cnt;
    logic          rpt_fire;

    assign rpt_fire = (cur_mode == MODE_SET) && change && change_q && !turn_rise &&
                      (rpt_cnt == RPT_LAST);
    assign inc      = change_rise | rpt_fire;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rpt_cnt <= '0;
        end else if (cur_mode != MODE_SET || !change || turn_rise) begin
            rpt_cnt <= '0;
        end else if (change_rise) begin
            rpt_cnt <= RW'(1);
        end else if (rpt_fire) begin
            rpt_cnt <= RPT_RELOAD;
        end else if (rpt_cnt != '0) begin
            rpt_cnt <= rpt_cnt + RW'(1);
        end
    end
`else
    assign inc = change_rise;
`endif

    // NOTE: sequential state uses non-blocking assignments so all cascaded fields update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sec      <= '0;
            min      <= '0;
            hour     <= '0;
            sel      <= SEL_HOUR;
            prescale <= '0;
            turn_q   <= 1'b0;
            change_q <= 1'b0;
            tick_m   <= 1'b0;
            tick_h   <= 1'b0;
            tick_d   <= 1'b0;
        end else begin
            turn_q   <= turn;
            change_q <= change;
            tick_m   <= 1'b0;
            tick_h   <= 1'b0;
            tick_d   <= 1'b0;
            // Outside RUN the prescaler sits at 0, so every entry into RUN starts a full period.
            prescale <= '0;
            case (cur_mode)
                MODE_RUN: begin
                    if (prescale != PRE_MAX) begin
                        prescale <= prescale + PW'(1);
                    end else if (sec != SEC_MAX) begin
                        sec <= sec + SW'(1);
                    end else begin
                        sec    <= '0;
                        tick_m <= 1'b1;
                        if (min != MIN_MAX) begin
                            min <= min + MW'(1);
                        end else begin
                            min    <= '0;
                            tick_h <= 1'b1;
                            if (hour != HOUR_MAX) begin
                                hour <= hour + HW'(1);
                            end else begin
                                hour   <= '0;
                                tick_d <= 1'b1;
                            end
                        end
                    end
                end
                MODE_SET: begin
                    if (inc) begin
                        case (sel_dec)
                            SEL_SEC:  sec  <= (sec  == SEC_MAX)  ? '0 : sec  + SW'(1);
                            SEL_MIN:  min  <= (min  == MIN_MAX)  ? '0 : min  + MW'(1);
                            default:  hour <= (hour == HOUR_MAX) ? '0 : hour + HW'(1);
                        endcase
                    end
                    if (turn_rise) begin
                        case (sel_dec)
                            SEL_HOUR: sel <= SEL_MIN;
                            SEL_MIN:  sel <= SEL_SEC;
                            default:  sel <= SEL_HOUR;
                        endcase
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_time_chain_ctrl.sv
// Self-checking bench for time_chain_ctrl: time-of-day model plus directed literal checks.
// Honours AUTO_REPEAT_EN when the macro is defined for the build.
module tb_time_chain_ctrl;

    localparam int TICK_DIV   = 4;
    localparam int SEC_MOD    = 60;
    localparam int MIN_MOD    = 60;
    localparam int HOUR_MOD   = 24;
    localparam int REPEAT_DLY = 16;
    localparam int REPEAT_PER = 4;
    localparam int DAY_SECS   = SEC_MOD * MIN_MOD * HOUR_MOD;

    logic                        clk = 1'b0;
    logic                        rst;
    logic [1:0]                  mode;
    logic                        turn;
    logic                        change;
    logic [$clog2(SEC_MOD)-1:0]  sec;
    logic [$clog2(MIN_MOD)-1:0]  min;
    logic [$clog2(HOUR_MOD)-1:0] hour;
    logic [1:0]                  sel;
    logic                        tick_m;
    logic                        tick_h;
    logic                        tick_d;

    int n_tests = 0;
    int n_fail  = 0;

    time_chain_ctrl #(
        .TICK_DIV  (TICK_DIV),
        .SEC_MOD   (SEC_MOD),
        .MIN_MOD   (MIN_MOD),
        .HOUR_MOD  (HOUR_MOD),
        .REPEAT_DLY(REPEAT_DLY),
        .REPEAT_PER(REPEAT_PER)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .mode  (mode),
        .turn  (turn),
        .change(change),
        .sec   (sec),
        .min   (min),
        .hour  (hour),
        .sel   (sel),
        .tick_m(tick_m),
        .tick_h(tick_h),
        .tick_d(tick_d)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model state: time-of-day as plain integers, selected field 0=SEC 1=MIN 2=HOUR.
    int m_s, m_m, m_h, m_sel, m_phase, m_held;
    bit m_tp, m_cp, e_tm, e_th, e_td;

    always @(posedge clk) begin
        bit tr, cr, run_m, set_m, inc;
        int total;
        tr    = turn && !m_tp;
        cr    = change && !m_cp;
        run_m = (mode == 2'b00);
        set_m = (mode == 2'b01);
        inc   = 1'b0;
        e_tm  = 1'b0;
        e_th  = 1'b0;
        e_td  = 1'b0;
        if (rst) begin
            m_s = 0; m_m = 0; m_h = 0; m_sel = 2;
            m_phase = 0; m_held = 0; m_tp = 0; m_cp = 0;
        end else begin
            if (run_m) begin
                if (m_phase == TICK_DIV - 1) begin
                    m_phase = 0;
                    total = ((m_h * MIN_MOD + m_m) * SEC_MOD + m_s + 1) % DAY_SECS;
                    m_s = total % SEC_MOD;
                    m_m = (total / SEC_MOD) % MIN_MOD;
                    m_h = total / (SEC_MOD * MIN_MOD);
                    e_tm = (m_s == 0);
                    e_th = e_tm && (m_m == 0);
                    e_td = e_th && (m_h == 0);
                end else begin
                    m_phase++;
                end
            end else begin
                m_phase = 0;
            end
            if (set_m) inc = cr;
`ifdef AUTO_REPEAT_EN
            // m_held = consecutive high samples since the arming edge, 0 when disarmed.
            if (!set_m || !change || tr) m_held = 0;
            else if (cr) m_held = 1;
            else if (m_held > 0) begin
                m_held++;
                if (m_held >= REPEAT_DLY && (m_held - REPEAT_DLY) % REPEAT_PER == 0) inc = 1'b1;
            end
`endif
            if (inc) begin
                if (m_sel == 0)      m_s = (m_s + 1) % SEC_MOD;
                else if (m_sel == 1) m_m = (m_m + 1) % MIN_MOD;
                else                 m_h = (m_h + 1) % HOUR_MOD;
            end
            if (set_m && tr) m_sel = (m_sel == 0) ? 2 : m_sel - 1;
            m_tp = turn;
            m_cp = change;
        end
        #1;
        check("model_sec",    32'(sec),    32'(m_s));
        check("model_min",    32'(min),    32'(m_m));
        check("model_hour",   32'(hour),   32'(m_h));
        check("model_sel",    32'(sel),    32'(m_sel));
        check("model_tick_m", 32'(tick_m), 32'(e_tm));
        check("model_tick_h", 32'(tick_h), 32'(e_th));
        check("model_tick_d", 32'(tick_d), 32'(e_td));
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_change(input int n);
        repeat (n) begin
            change = 1'b1;
            @(negedge clk);
            change = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic pulse_turn();
        turn = 1'b1;
        @(negedge clk);
        turn = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        rst    = 1'b1;
        mode   = 2'b00;
        turn   = 1'b0;
        change = 1'b0;
        cycles(2);
        check("reset_sec",    32'(sec),    0);
        check("reset_hour",   32'(hour),   0);
        check("reset_sel",    32'(sel),    2);
        check("reset_tick_m", 32'(tick_m), 0);

        // First seconds tick lands on the 4th RUN edge after release.
        rst = 1'b0;
        cycles(3);
        check("run_sec_edge3", 32'(sec), 0);
        cycles(1);
        check("run_sec_edge4", 32'(sec),    1);
        check("run_min_edge4", 32'(min),    0);
        check("run_tickm_e4",  32'(tick_m), 0);

        // Preload 23:59:59 through SET.
        mode = 2'b01;
        pulse_change(23);
        pulse_turn();
        pulse_change(59);
        pulse_turn();
        pulse_change(58);
        check("preload_hour", 32'(hour), 23);
        check("preload_min",  32'(min),  59);
        check("preload_sec",  32'(sec),  59);
        check("preload_sel",  32'(sel),  0);
        pulse_turn();
        check("sel_wrap_hour", 32'(sel), 2);

        // Day rollover with all three ticks together for one cycle.
        mode = 2'b00;
        cycles(3);
        check("pre_roll_sec", 32'(sec), 59);
        cycles(1);
        check("roll_hour",   32'(hour),   0);
        check("roll_min",    32'(min),    0);
        check("roll_sec",    32'(sec),    0);
        check("roll_tick_m", 32'(tick_m), 1);
        check("roll_tick_h", 32'(tick_h), 1);
        check("roll_tick_d", 32'(tick_d), 1);
        cycles(1);
        check("roll_tick_d_clear", 32'(tick_d), 0);

        // Hour field wraps modulo 24 without carry.
        mode = 2'b01;
        pulse_change(25);
        check("hour_mod_wrap", 32'(hour), 1);
        check("hour_no_carry", 32'(min),  0);

        // Simultaneous turn and change: increment old field, then advance.
        turn   = 1'b1;
        change = 1'b1;
        cycles(1);
        check("simul_hour", 32'(hour), 2);
        check("simul_sel",  32'(sel),  1);
        check("simul_min",  32'(min),  0);
        turn   = 1'b0;
        change = 1'b0;
        cycles(1);

        // HOLD mid-period: frozen, inputs ignored, full period after re-entry.
        mode = 2'b00;
        cycles(2);
        mode = 2'b10;
        pulse_change(2);
        pulse_turn();
        cycles(2);
        check("hold_sec",  32'(sec),  0);
        check("hold_hour", 32'(hour), 2);
        check("hold_sel",  32'(sel),  1);
        mode = 2'b00;
        pulse_turn();
        cycles(1);
        check("rerun_sec_e3", 32'(sec), 0);
        cycles(1);
        check("rerun_sec_e4", 32'(sec), 1);
        check("run_turn_ign", 32'(sel), 1);

        // Held change on SEC from 0.
        mode = 2'b01;
        pulse_turn();
        pulse_change(59);
        check("sec_to_zero", 32'(sec), 0);
        change = 1'b1;
        cycles(28);
        change = 1'b0;
        cycles(1);
`ifdef AUTO_REPEAT_EN
        check("held_change_sec", 32'(sec), 5);
`else
        check("held_change_sec", 32'(sec), 1);
`endif

        // Asynchronous reset mid-operation takes effect before any clock edge.
        mode = 2'b00;
        cycles(6);
        check("pre_rst_hour", 32'(hour), 2);
        #2 rst = 1'b1;
        #1;
        check("async_rst_hour", 32'(hour), 0);
        check("async_rst_sel",  32'(sel),  2);
        check("async_rst_sec",  32'(sec),  0);
        @(negedge clk);
        rst = 1'b0;
        cycles(10);
        mode = 2'b10;
        cycles(3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
